// File: rtl/seven_seg_reader_if.sv
// seven_seg_reader_if
// Bundles the segment inputs, the valid/ready result handshake and the error
// counter of the seven-segment readback block.
//   master : drives i_seven_ten, i_seven_one, i_ready; observes the result fields
//   slave  : the reader itself; consumes the segment pair and ready, drives results
// Signals:
//   i_seven_ten [6:0] tens-digit pattern, active-low
//   i_seven_one [6:0] ones-digit pattern, active-low
//   i_ready           consumer accepts the current result
//   o_valid           result available
//   o_value     [5:0] recovered value 0..35 (0 for blank/overflow/error)
//   o_blank           dark/dark code
//   o_overflow        7/7 code
//   o_error           illegal pattern pair
//   o_err_cnt   [7:0] saturating count of accepted error results
interface seven_seg_reader_if;
  logic [6:0] i_seven_ten;
  logic [6:0] i_seven_one;
  logic       i_ready;
  logic       o_valid;
  logic [5:0] o_value;
  logic       o_blank;
  logic       o_overflow;
  logic       o_error;
  logic [7:0] o_err_cnt;

  modport master (
    output i_seven_ten, i_seven_one, i_ready,
    input  o_valid, o_value, o_blank, o_overflow, o_error, o_err_cnt
  );

  modport slave (
    input  i_seven_ten, i_seven_one, i_ready,
    output o_valid, o_value, o_blank, o_overflow, o_error, o_err_cnt
  );
endinterface

// File: rtl/seven_seg_reader.sv
// seven_seg_reader
// Receive end of the two-digit seven-segment path. Registers the tens/ones
// active-low patterns, waits until the pair has held for STABLE_CYCLES samples,
// classifies it (legal 0..35, blank, overflow, error) and presents each new
// result once on a valid/ready handshake.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      seven_seg_reader_if.slave (segment inputs, handshake, result fields)
// Parameter:
//   STABLE_CYCLES  identical consecutive samples required (1..255)
// Optional feature:
//   SEVEN_SEG_READER_ERRCNT_EN  when defined, o_err_cnt counts completed
//   handshakes carrying o_error (saturating at 255); otherwise o_err_cnt is 0.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  seven_seg_reader_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // Digit decode codes beyond 0..9
  localparam logic [3:0] DIG_DARK = 4'd10;
  localparam logic [3:0] DIG_BAD  = 4'd15;

  // Map an active-low pattern (bit6..bit0) to its digit, dark or bad marker.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] dig;
    case (seg)
      7'b1000000: dig = 4'd0;
      7'b1111001: dig = 4'd1;
      7'b0100100: dig = 4'd2;
      7'b0110000: dig = 4'd3;
      7'b0011001: dig = 4'd4;
      7'b0010010: dig = 4'd5;
      7'b0000010: dig = 4'd6;
      7'b1011000: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0010000: dig = 4'd9;
      7'b1111111: dig = DIG_DARK;
      default:    dig = DIG_BAD;
    endcase
    return dig;
  endfunction

  logic [13:0]      sample_r;
  logic [CNT_W-1:0] cnt_r;
  logic [0:0]       state_r;
  logic             first_r;
  logic [13:0]      last_r;
  logic             valid_r;
  logic [5:0]       value_r;
  logic             blank_r;
  logic             overflow_r;
  logic             error_r;

  logic [13:0] in_pair_s;
  logic [3:0]  ten_d_s;
  logic [3:0]  one_d_s;
  logic [6:0]  val_s;
  logic        blank_s;
  logic        overflow_s;
  logic        legal_s;
  logic        error_s;
  logic        stable_s;
  logic        load_s;

  assign in_pair_s = {bus.i_seven_ten, bus.i_seven_one};

  // Input sampling register and stability counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_r <= 14'd0;
      cnt_r    <= '0;
    end else begin
      sample_r <= in_pair_s;
      // The comparison against the old sample means a change restarts the
      // count on the same edge that captures the new pair.
      if (in_pair_s != sample_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Classification of the registered pair.
  always_comb begin
    ten_d_s    = seg_decode(sample_r[13:7]);
    one_d_s    = seg_decode(sample_r[6:0]);
    val_s      = 7'(ten_d_s) * 7'd10 + 7'(one_d_s);
    blank_s    = (ten_d_s == DIG_DARK) && (one_d_s == DIG_DARK);
    overflow_s = (ten_d_s == 4'd7) && (one_d_s == 4'd7);
    legal_s    = (ten_d_s <= 4'd3) && (one_d_s <= 4'd9) && (val_s <= 7'd35);
    error_s    = !blank_s && !overflow_s && !legal_s;
    stable_s   = (cnt_r == CNT_MAX);
    load_s     = stable_s && (first_r || (sample_r != last_r));
  end

  // Result FSM: capture a new stable pair in IDLE, hold it in PRESENT until taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      first_r    <= 1'b1;
      last_r     <= 14'd0;
      valid_r    <= 1'b0;
      value_r    <= 6'd0;
      blank_r    <= 1'b0;
      overflow_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            value_r    <= legal_s ? val_s[5:0] : 6'd0;
            blank_r    <= blank_s;
            overflow_r <= overflow_s;
            error_r    <= error_s;
            last_r     <= sample_r;
            first_r    <= 1'b0;
            valid_r    <= 1'b1;
            state_r    <= ST_PRESENT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (bus.i_ready) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_PRESENT;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_valid    = valid_r;
  assign bus.o_value    = value_r;
  assign bus.o_blank    = blank_r;
  assign bus.o_overflow = overflow_r;
  assign bus.o_error    = error_r;

`ifdef SEVEN_SEG_READER_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of error results taken by the consumer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (valid_r && bus.i_ready && error_r && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.o_err_cnt = err_cnt_r;
`else
  assign bus.o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader
// Scoreboard bench for seven_seg_reader. A reference model tracks the recent
// input history as a queue and decides when a result is due; expected results
// are queued and a monitor compares the DUT result fields against the head of
// the queue on every cycle the DUT presents a result.
module tb_seven_seg_reader;

  localparam int S = 4;

  typedef struct packed {
    logic [5:0] value;
    logic       blank;
    logic       ovf;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seven_seg_reader_if bus();

  seven_seg_reader #(.STABLE_CYCLES(S)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Digit table, index 10 is the dark pattern
  logic [6:0] dig [0:10];

  // Model state
  logic [13:0] hist[$];
  exp_t        expq[$];
  logic        first_m;
  logic [13:0] last_m;
  int          exp_errs;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_dig(input logic [6:0] p);
    for (int i = 0; i <= 10; i++) if (dig[i] == p) return i;
    return -1;
  endfunction

  function automatic exp_t ref_classify(input logic [13:0] pair);
    exp_t r;
    int t, o;
    t = find_dig(pair[13:7]);
    o = find_dig(pair[6:0]);
    r = '0;
    if (t == 10 && o == 10) r.blank = 1'b1;
    else if (t == 7 && o == 7) r.ovf = 1'b1;
    else if (t >= 0 && t <= 3 && o >= 0 && o <= 9 && (t * 10 + o) <= 35)
      r.value = 6'(t * 10 + o);
    else r.err = 1'b1;
    return r;
  endfunction

  function automatic bit hist_stable();
    if (hist.size() != S + 1) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(14'd0);
    expq.delete();
    first_m  = 1'b1;
    last_m   = 14'd0;
    exp_errs = 0;
  endtask

  task automatic model_loop();
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (expq.size() != 0) begin
          if (bus.i_ready) begin
            e = expq.pop_front();
            if (e.err && exp_errs < 255) exp_errs++;
          end
        end else if (hist_stable() && (first_m || hist[$] != last_m)) begin
          expq.push_back(ref_classify(hist[$]));
          last_m  = hist[$];
          first_m = 1'b0;
        end
        hist.push_back({bus.i_seven_ten, bus.i_seven_one});
        if (hist.size() > S + 1) void'(hist.pop_front());
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid", int'(bus.o_valid), int'(expq.size() != 0));
        if (bus.o_valid && expq.size() != 0) begin
          a = {bus.o_value, bus.o_blank, bus.o_overflow, bus.o_error};
          check("result", int'(a), int'(expq[0]));
        end
      end
    end
  endtask

  // Drive a pair and hold it for n edges; returns #1 after the last edge.
  task automatic hold(input int t, input int o, input int n);
    bus.i_seven_ten = dig[t];
    bus.i_seven_one = dig[o];
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until o_valid is seen; 99 on timeout.
  task automatic wait_valid(output int n);
    n = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({bus.o_valid, bus.o_value, bus.o_blank, bus.o_overflow,
                      bus.o_error, bus.o_err_cnt}), 0);
  endtask

  function automatic int exp_errcnt();
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    return exp_errs;
`else
    return 0;
`endif
  endfunction

  initial begin
    int n;
    dig[0] = 7'b1000000; dig[1] = 7'b1111001; dig[2] = 7'b0100100;
    dig[3] = 7'b0110000; dig[4] = 7'b0011001; dig[5] = 7'b0010010;
    dig[6] = 7'b0000010; dig[7] = 7'b1011000; dig[8] = 7'b0000000;
    dig[9] = 7'b0010000; dig[10] = 7'b1111111;

    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_seven_ten = dig[10];
    bus.i_seven_one = dig[10];
    model_reset();
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // First pair after reset (blank) is reported
    wait_valid(n);
    check("lat_first", n, S + 2);
    hold(10, 10, 10);

    // 27 with ready held high: one pulse after S+2 edges, no repeat
    bus.i_seven_ten = dig[2];
    bus.i_seven_one = dig[7];
    wait_valid(n);
    check("lat_27", n, S + 2);
    check("val_27", int'(bus.o_value), 27);
    hold(2, 7, 15);

    // Glitching ones digit, then settle on 3
    for (int i = 0; i < 6; i++) hold(0, (i % 2 == 0) ? 1 : 3, 3);
    hold(0, 3, 12);

    // Blank, overflow, legal 7
    hold(10, 10, 10);
    hold(7, 7, 10);
    hold(0, 7, 10);

    // Illegal pairs
    hold(3, 6, 10);
    hold(4, 0, 10);
    hold(10, 5, 10);
    check("err_cnt_3", int'(bus.o_err_cnt), exp_errcnt());
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    check("err_cnt_abs", int'(bus.o_err_cnt), 3);
`endif

    // Back-pressure: 12 held, 20 superseded by 33
    bus.i_ready = 1'b0;
    bus.i_seven_ten = dig[1];
    bus.i_seven_one = dig[2];
    wait_valid(n);
    check("val_12", int'(bus.o_value), 12);
    hold(2, 0, 8);
    hold(3, 3, 8);
    check("held_12", int'(bus.o_value), 12);
    bus.i_ready = 1'b1;
    hold(3, 3, 12);

    // Reset while presenting 15, then 15 re-reported
    bus.i_ready = 1'b0;
    hold(1, 5, 10);
    rst_n = 1'b0;
    hold(1, 5, 2);
    check_reset_outputs("reset_mid");
    bus.i_ready = 1'b1;
    rst_n = 1'b1;
    wait_valid(n);
    check("lat_15", n, S + 2);
    check("val_15", int'(bus.o_value), 15);
    hold(1, 5, 8);

    // Random pairs, hold lengths and back-pressure
    for (int i = 0; i < 300; i++) begin
      bus.i_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 8) begin
        bus.i_seven_ten = dig[$urandom_range(0, 10)];
        bus.i_seven_one = dig[$urandom_range(0, 10)];
      end else begin
        bus.i_seven_ten = 7'($urandom);
        bus.i_seven_one = dig[$urandom_range(0, 10)];
      end
      repeat ($urandom_range(1, 8)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.i_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("drained", expq.size(), 0);
    check("err_cnt_end", int'(bus.o_err_cnt), exp_errcnt());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
